c499_resp_checker: RTL and testbench
====================================

# c499_resp_checker

Synthesizable response checker for the c499 vector flow. It consumes the 32-bit c499 output word once per applied vector and compares it against a golden table loaded beforehand. It accumulates an error count, the first failing index and a MISR signature, replacing the file dump with on-chip pass/fail. It sits downstream of the c499 instance, on the opposite end of the stimulus-vector stream.

## Interface
- DATA_W, 32, response width (c499 outputs N724..N755, N724 = MSB)
- VEC_LEN, 31, vectors per run
- IDX_W, $clog2(VEC_LEN), golden address / index width
- CNT_W, $clog2(VEC_LEN+1), error counter width
- MISR_POLY, 32'h04C11DB7, MISR feedback polynomial
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- exp_we  in  1  golden-table write strobe
- exp_addr  in  IDX_W  golden-table write address
- exp_data  in  DATA_W  golden word
- start  in  1  one-cycle pulse; begins a run
- rsp_valid  in  1  response word present
- rsp_data  in  DATA_W  c499 response word
- rsp_ready  out  1  checker accepts a response
- busy  out  1  run in progress
- done  out  1  run complete, results stable
- pass  out  1  done && err_cnt == 0
- err_cnt  out  CNT_W  mismatching responses this run
- first_err_vld  out  1  at least one mismatch seen
- first_err_idx  out  IDX_W  index of first mismatch
- signature  out  DATA_W  MISR over accepted responses

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE + start: go to RUN and clear the following:
  - idx, err_cnt, first_err_vld and first_err_idx to 0
  - signature to 0
- RUN + start: restart with the same clears; the response offered that cycle is not accepted.
- DONE + start: go to RUN with the same clears.
- rsp_ready = (state == RUN) && !start.
- Accept = rsp_valid && rsp_ready. On each accept:
  - compare rsp_data against gold[idx] (combinational read); mismatch if any bit differs
  - on mismatch: err_cnt += 1; if !first_err_vld, set first_err_vld = 1 and first_err_idx = idx
  - signature <= {sig[DATA_W-2:0],1'b0} ^ (sig[DATA_W-1] ? MISR_POLY : 0) ^ rsp_data
  - idx += 1; if idx == VEC_LEN-1, go to DONE instead of incrementing
- err_cnt cannot exceed VEC_LEN, so no saturation logic is needed.
- Golden table writes occur only when state != RUN. exp_we in RUN is ignored, so the table is frozen during a run.
- exp_addr >= VEC_LEN is ignored.
- The golden table is not cleared by reset; its contents are undefined until written.
- A reset mid-run aborts the run: all outputs go to reset values and the state returns to IDLE.

## Timing
- Reset values:
  - rsp_ready = 0, busy = 0, done = 0, pass = 0
  - err_cnt = 0, first_err_vld = 0, first_err_idx = 0, signature = 0
- Zero-cycle compare latency. Counters and signature update at the accepting edge and are visible the next cycle.
- busy = 1 from the cycle after start through the cycle of the last accept.
- done rises the cycle after the last accept and holds until the next start or reset.
- pass is valid only while done = 1.
- Throughput: one response per cycle. rsp_valid may stay high across gaps; there is no backpressure apart from rsp_ready.
- A golden write in the same cycle as start is still accepted, because the state is not yet RUN.

## Structure
- Package c499_chk_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default DATA_W, VEC_LEN and MISR_POLY constants
  - a function computing the MISR next state
- Sub-module c499_misr: a parameterised DATA_W MISR with clk, rst_n, clr, en, din and sig. The checker drives clr from start and en from accept.
- Golden table: a register array of VEC_LEN x DATA_W with a write port and a combinational read.

## Test plan
- Reset: assert rst_n = 0 mid-run after 10 accepts. Required: all outputs at reset values and state IDLE; after a new start, the run restarts at idx 0.
- All match: load gold[i] = 32'hA5A5_0000 + i, start, then stream identical words. Required: done one cycle after accept #31, pass = 1, err_cnt = 0, signature equal to the reference-model MISR.
- Single error: same table, with response #7 bit 0 flipped. Required: err_cnt = 1, first_err_vld = 1, first_err_idx = 7, pass = 0.
- Multiple errors plus gaps: errors at indices 3, 3+1 and 30, with rsp_valid deasserted for random gaps. Required: err_cnt = 3, first_err_idx = 3, no accept while rsp_valid = 0, done after exactly 31 accepts.
- Restart and write lockout: pulse start at idx 12 with rsp_valid = 1; issue exp_we during RUN to address 0 with 32'hFFFF_FFFF. Required:
  - no accept in the start cycle
  - counters and signature cleared
  - gold[0] unchanged; index-0 compare still matches
- Out-of-range and back-to-back: write exp_addr = 31 with 32'h0, run to DONE, then pulse start in the first DONE cycle. Required: table unchanged, second run completes with identical signature, done low during the run.

Source files
------------

// File: rtl/c499_chk_pkg.sv
// Shared types and constants for the c499 response checker.
// Holds the run-state enum and the MISR step function.
package c499_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned C499_DATA_W  = 32;
  localparam int unsigned C499_VEC_LEN = 31;
  localparam logic [C499_DATA_W-1:0] C499_MISR_POLY = 32'h04C11DB7;

  // Shift left, fold the MSB back through the polynomial, then mix in the new word.
  function automatic logic [C499_DATA_W-1:0] misr_next(
    input logic [C499_DATA_W-1:0] sig,
    input logic [C499_DATA_W-1:0] din,
    input logic [C499_DATA_W-1:0] poly
  );
    return {sig[C499_DATA_W-2:0], 1'b0} ^ (sig[C499_DATA_W-1] ? poly : '0) ^ din;
  endfunction

endpackage

// File: rtl/c499_misr.sv
// Multiple-input signature register; clr wins over en, result visible next cycle.
// No backpressure: folds din in on every cycle en is high.
module c499_misr
  import c499_chk_pkg::*;
#(
  parameter int unsigned DATA_W = C499_DATA_W,
  parameter logic [DATA_W-1:0] POLY = C499_MISR_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sig
);

  logic [DATA_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_next(sig_q, din, POLY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/c499_resp_checker.sv
// Compares each c499 response against a preloaded golden table: zero-cycle compare,
// results visible the cycle after accept; rsp_ready is the only backpressure (low outside RUN).
module c499_resp_checker
  import c499_chk_pkg::*;
#(
  parameter int unsigned DATA_W  = C499_DATA_W,
  parameter int unsigned VEC_LEN = C499_VEC_LEN,
  parameter int unsigned IDX_W   = $clog2(VEC_LEN),
  parameter int unsigned CNT_W   = $clog2(VEC_LEN + 1),
  parameter logic [DATA_W-1:0] MISR_POLY = C499_MISR_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_err_vld,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] signature
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              first_err_vld_q, first_err_vld_d;
  logic [IDX_W-1:0]  first_err_idx_q, first_err_idx_d;
  logic [DATA_W-1:0] gold_q [VEC_LEN];
  logic [DATA_W-1:0] gold_d [VEC_LEN];

  logic accept;
  logic mismatch;
  logic last;
  logic gold_we;

  assign accept   = rsp_valid && rsp_ready;
  assign mismatch = (rsp_data != gold_q[idx_q]);
  assign last     = (idx_q == IDX_W'(VEC_LEN - 1));
  // Table is frozen while a run is in progress so every compare sees one snapshot.
  assign gold_we  = exp_we && (state_q != ST_RUN) && (32'(exp_addr) < VEC_LEN);

  always_comb begin
    gold_d = gold_q;
    if (gold_we) begin
      gold_d[exp_addr] = exp_data;
    end
  end

  always_ff @(posedge clk) begin
    gold_q <= gold_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (start) begin
          state_d = ST_RUN;
        end else if (accept && last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_ready = (state_q == ST_RUN) && !start;
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    pass      = (state_q == ST_DONE) && (err_cnt_q == '0);
  end

  always_comb begin
    idx_d           = idx_q;
    err_cnt_d       = err_cnt_q;
    first_err_vld_d = first_err_vld_q;
    first_err_idx_d = first_err_idx_q;
    if (start) begin
      idx_d           = '0;
      err_cnt_d       = '0;
      first_err_vld_d = 1'b0;
      first_err_idx_d = '0;
    end else if (accept) begin
      if (mismatch) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
        if (!first_err_vld_q) begin
          first_err_vld_d = 1'b1;
          first_err_idx_d = idx_q;
        end
      end
      if (!last) begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q           <= '0;
      err_cnt_q       <= '0;
      first_err_vld_q <= 1'b0;
      first_err_idx_q <= '0;
    end else begin
      idx_q           <= idx_d;
      err_cnt_q       <= err_cnt_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  c499_misr #(
    .DATA_W (DATA_W),
    .POLY   (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (accept),
    .din   (rsp_data),
    .sig   (signature)
  );

  assign err_cnt       = err_cnt_q;
  assign first_err_vld = first_err_vld_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_c499_resp_checker.sv
// Bench for c499_resp_checker: scenario table plus hand sequences, every cycle
// checked against a queue-based model of the run.
module tb_c499_resp_checker;

  localparam int N = 31;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        start;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_cnt;
  logic        first_err_vld;
  logic [4:0]  first_err_idx;
  logic [31:0] signature;

  always #5 clk = ~clk;

  c499_resp_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .exp_we        (exp_we),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .start         (start),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_err_vld (first_err_vld),
    .first_err_idx (first_err_idx),
    .signature     (signature)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 running, 2 finished; accepted words and failing indices.
  bit [31:0] m_gold [N];
  int        m_st = 0;
  bit [31:0] m_words [$];
  int        m_errs [$];
  int        acc_cnt = 0;

  typedef struct {
    bit [30:0] mask;
    int        gap;
    int        fbit;
    int        exp_err;
    int        exp_first;
    bit        exp_pass;
  } scen_t;

  scen_t tbl [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signature as repeated multiply-by-x modulo POLY over GF(2), adding each word.
  function automatic bit [31:0] m_sig();
    bit [31:0] s = '0;
    foreach (m_words[k]) begin
      s = (s << 1) ^ (s[31] ? POLY : 32'd0) ^ m_words[k];
    end
    return s;
  endfunction

  // One clock: drive just after posedge, check at negedge, advance model at posedge.
  task automatic cyc(input bit st, input bit vld, input logic [31:0] d,
                     input bit we = 1'b0, input logic [4:0] a = '0,
                     input logic [31:0] wd = '0);
    bit acc_m;
    start = st; rsp_valid = vld; rsp_data = d;
    exp_we = we; exp_addr = a; exp_data = wd;
    @(negedge clk);
    acc_m = (m_st == 1) && !st && vld;
    chk("rsp_ready", rsp_ready, (m_st == 1) && !st);
    chk("busy", busy, m_st == 1);
    chk("done", done, m_st == 2);
    chk("pass", pass, (m_st == 2) && (m_errs.size() == 0));
    chk("err_cnt", err_cnt, m_errs.size());
    chk("first_err_vld", first_err_vld, m_errs.size() != 0);
    chk("first_err_idx", first_err_idx, (m_errs.size() != 0) ? m_errs[0] : 0);
    chk("signature", signature, m_sig());
    if (rsp_valid && rsp_ready) acc_cnt++;
    @(posedge clk);
    if (we && m_st != 1 && int'(a) < N) m_gold[a] = wd;
    if (st) begin
      m_st = 1;
      m_words.delete();
      m_errs.delete();
      acc_cnt = 0;
    end else if (acc_m) begin
      if (d != m_gold[m_words.size()]) m_errs.push_back(m_words.size());
      m_words.push_back(d);
      if (m_words.size() == N) m_st = 2;
    end
    #1;
  endtask

  // Stream responses until the model sees the run finish; mask selects corrupted indices.
  task automatic run(input bit do_start, input bit [30:0] mask, input int gap, input int fbit);
    int n = 0;
    int i;
    bit v;
    logic [31:0] d;
    logic [31:0] flip;
    if (do_start) cyc(1'b1, 1'($urandom_range(0, 1)), $urandom);
    while (m_st != 2 && n < 1000) begin
      i = m_words.size();
      v = ($urandom_range(0, 99) >= gap);
      flip = (fbit >= 0) ? (32'd1 << fbit) : (32'd1 << $urandom_range(0, 31));
      d = m_gold[i] ^ (mask[i] ? flip : 32'd0);
      cyc(1'b0, v, v ? d : $urandom);
      n++;
    end
    if (n >= 1000) begin
      errors++;
      $display("FAIL run_bound got %0d cycles want under 1000", n);
    end
  endtask

  logic [31:0] sig1;

  initial begin
    tbl[0] = '{mask: 31'd0, gap: 0, fbit: -1, exp_err: 0, exp_first: 0, exp_pass: 1'b1};
    tbl[1] = '{mask: 31'd1 << 7, gap: 0, fbit: 0, exp_err: 1, exp_first: 7, exp_pass: 1'b0};
    tbl[2] = '{mask: (31'd1 << 3) | (31'd1 << 4) | (31'd1 << 30), gap: 40, fbit: -1,
               exp_err: 3, exp_first: 3, exp_pass: 1'b0};

    rst_n = 1'b0;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, '0);
    m_st = 0;
    m_words.delete();
    m_errs.delete();
    cyc(1'b0, 1'b1, '0);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) cyc(1'b0, 1'b0, '0, 1'b1, 5'(i), 32'hA5A5_0000 + i);

    foreach (tbl[s]) begin
      run(1'b1, tbl[s].mask, tbl[s].gap, tbl[s].fbit);
      cyc(1'b0, 1'b0, '0);
      chk("scen_err_cnt", err_cnt, tbl[s].exp_err);
      chk("scen_first_vld", first_err_vld, tbl[s].exp_err != 0);
      chk("scen_first_idx", first_err_idx, tbl[s].exp_first);
      chk("scen_pass", pass, tbl[s].exp_pass);
      chk("scen_done", done, 1'b1);
      chk("scen_accepts", acc_cnt, N);
      chk("scen_sig", signature, m_sig());
    end

    // Reset mid-run after 10 accepts, one of them a mismatch.
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, m_gold[i] ^ ((i == 2) ? 32'h10 : 32'h0));
    rst_n = 1'b0;
    #2;
    chk("rst_rsp_ready", rsp_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_vld", first_err_vld, 1'b0);
    chk("rst_first_idx", first_err_idx, 0);
    chk("rst_signature", signature, 0);
    m_st = 0;
    m_words.delete();
    m_errs.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, $urandom);
    run(1'b1, 31'd1, 0, 3);
    cyc(1'b0, 1'b0, '0);
    chk("rst_rerun_first_idx", first_err_idx, 0);
    chk("rst_rerun_err_cnt", err_cnt, 1);
    chk("rst_rerun_accepts", acc_cnt, N);

    // Restart at idx 12 plus write lockout; a write alongside start from DONE is taken.
    cyc(1'b1, 1'b0, '0, 1'b1, 5'd5, 32'h1234_5678);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, m_gold[i] ^ ((i == 1) ? 32'h4 : 32'h0));
    cyc(1'b1, 1'b1, m_gold[12]);
    cyc(1'b0, 1'b0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("restart_err_cnt", err_cnt, 0);
    chk("restart_sig", signature, 0);
    run(1'b0, 31'd0, 20, -1);
    cyc(1'b0, 1'b0, '0);
    chk("lockout_err_cnt", err_cnt, 0);
    chk("lockout_first_vld", first_err_vld, 1'b0);
    chk("lockout_pass", pass, 1'b1);
    chk("lockout_accepts", acc_cnt, N);

    // Out-of-range write, then back-to-back runs with start in the first DONE cycle.
    cyc(1'b0, 1'b0, '0, 1'b1, 5'd31, 32'h0);
    run(1'b1, 31'd0, 0, -1);
    sig1 = signature;
    chk("b2b_sig1", sig1, m_sig());
    run(1'b1, 31'd0, 30, -1);
    cyc(1'b0, 1'b0, '0);
    chk("b2b_sig_repeat", signature, sig1);
    chk("b2b_err_cnt", err_cnt, 0);
    chk("b2b_pass", pass, 1'b1);
    chk("b2b_accepts", acc_cnt, N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
